// File: rtl/sdram_p2_arbiter_if.sv
// Bundle between the p2 arbiter, its requesting clients and the SDRAM
// controller's secondary port.
//
// Handshake: a client raises req[i] (with we/addr/ds/din valid) and holds it
// until it sees the one-cycle ack[i] pulse; err qualifies that pulse and dout
// holds the data of the last completed read. Towards the controller p2_cs
// and p2_* stay stable while an access is outstanding; the controller reports
// completion by toggling p2_ack once, with p2_dout valid at that time.
interface sdram_p2_arbiter_if #(
    parameter int NUM_CLIENTS = 3
);
    logic                      ready;
    logic [NUM_CLIENTS-1:0]    req;
    logic [NUM_CLIENTS-1:0]    we;
    logic [NUM_CLIENTS*22-1:0] addr;
    logic [NUM_CLIENTS*2-1:0]  ds;
    logic [NUM_CLIENTS*16-1:0] din;
    logic [NUM_CLIENTS-1:0]    ack;
    logic                      err;
    logic [15:0]               dout;
    logic                      p2_cs;
    logic                      p2_we;
    logic [21:0]               p2_addr;
    logic [1:0]                p2_ds;
    logic [15:0]               p2_din;
    logic [15:0]               p2_dout;
    logic                      p2_ack;
    logic [1:0]                dbg_state;

    modport slave (
        input  ready, req, we, addr, ds, din, p2_dout, p2_ack,
        output ack, err, dout, p2_cs, p2_we, p2_addr, p2_ds, p2_din, dbg_state
    );

    modport master (
        output ready, req, we, addr, ds, din, p2_dout, p2_ack,
        input  ack, err, dout, p2_cs, p2_we, p2_addr, p2_ds, p2_din, dbg_state
    );
endinterface

// File: rtl/sdram_p2_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's p2 port among
// NUM_CLIENTS requesters. The winner's request is latched onto p2_* and held
// until the controller toggles p2_ack; the client then gets a one-cycle ack.
// Optional feature macro: SDRAM_ARB_TIMEOUT_EN adds a BUSY timeout with an
// abort ack (err=1) followed by a DRAIN period that swallows a late toggle.
module sdram_p2_arbiter #(
    parameter int NUM_CLIENTS    = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DRAIN_CYCLES   = 16
) (
    input logic             clk,
    input logic             reset,
    sdram_p2_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_CLIENTS);

    // Reject configurations the counters and index widths cannot represent.
    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 4 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
        DRAIN_CYCLES < 1 || DRAIN_CYCLES > 256) begin : g_bad_cfg
        $error("sdram_p2_arbiter: parameter out of range");
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_GAP = 2'd2, S_DRAIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_GAP = 2'd2} state_t;
`endif

    state_t                 state_q, state_d;
    logic [GW-1:0]          rr_last_q, rr_last_d;
    logic [GW-1:0]          gnt_q, gnt_d;
    logic                   ack_ref_q, ack_ref_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic [15:0]            dout_q, dout_d;
    logic                   p2_cs_q, p2_cs_d;
    logic                   p2_we_q, p2_we_d;
    logic [21:0]            p2_addr_q, p2_addr_d;
    logic [1:0]             p2_ds_q, p2_ds_d;
    logic [15:0]            p2_din_q, p2_din_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
    logic                   err_q, err_d;
    logic [7:0]             cnt_q, cnt_d;
`endif

    // Per-client views of the packed request buses.
    logic [21:0] addr_a [NUM_CLIENTS];
    logic [1:0]  ds_a   [NUM_CLIENTS];
    logic [15:0] din_a  [NUM_CLIENTS];
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_a[i] = bus.addr[22*i +: 22];
        assign ds_a[i]   = bus.ds[2*i +: 2];
        assign din_a[i]  = bus.din[16*i +: 16];
    end

    // The controller signals completion by changing the p2_ack level.
    logic p2_done;
    assign p2_done = (bus.p2_ack != ack_ref_q);

    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [GW-1:0] scan_idx;

    // Round-robin pick: first set req starting after the last winner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = rr_last_q;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            scan_idx = (scan_idx == GW'(NUM_CLIENTS - 1)) ? '0 : scan_idx + GW'(1);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and registered-output computation for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        gnt_d     = gnt_q;
        ack_ref_d = ack_ref_q;
        ack_d     = '0;
        dout_d    = dout_q;
        p2_cs_d   = p2_cs_q;
        p2_we_d   = p2_we_q;
        p2_addr_d = p2_addr_q;
        p2_ds_d   = p2_ds_q;
        p2_din_d  = p2_din_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
        err_d     = 1'b0;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                p2_cs_d = 1'b0;
                if (bus.ready && win_found) begin
                    p2_cs_d   = 1'b1;
                    p2_we_d   = bus.we[win_idx];
                    p2_addr_d = addr_a[win_idx];
                    p2_ds_d   = ds_a[win_idx];
                    p2_din_d  = din_a[win_idx];
                    gnt_d     = win_idx;
                    rr_last_d = win_idx;
                    state_d   = S_BUSY;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end
            end
            S_BUSY: begin
                if (p2_done) begin
                    ack_ref_d    = bus.p2_ack;
                    p2_cs_d      = 1'b0;
                    if (!p2_we_q) dout_d = bus.p2_dout;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_GAP;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    p2_cs_d      = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    err_d        = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            S_DRAIN: begin
                if (cnt_q == 8'(DRAIN_CYCLES - 1)) begin
                    ack_ref_d = bus.p2_ack;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset resyncs ack_ref to the live p2_ack level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_last_q <= GW'(NUM_CLIENTS - 1);
            gnt_q     <= '0;
            ack_ref_q <= bus.p2_ack;
            ack_q     <= '0;
            dout_q    <= '0;
            p2_cs_q   <= 1'b0;
            p2_we_q   <= 1'b0;
            p2_addr_q <= '0;
            p2_ds_q   <= '0;
            p2_din_q  <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            gnt_q     <= gnt_d;
            ack_ref_q <= ack_ref_d;
            ack_q     <= ack_d;
            dout_q    <= dout_d;
            p2_cs_q   <= p2_cs_d;
            p2_we_q   <= p2_we_d;
            p2_addr_q <= p2_addr_d;
            p2_ds_q   <= p2_ds_d;
            p2_din_q  <= p2_din_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.ack       = ack_q;
    assign bus.dout      = dout_q;
    assign bus.p2_cs     = p2_cs_q;
    assign bus.p2_we     = p2_we_q;
    assign bus.p2_addr   = p2_addr_q;
    assign bus.p2_ds     = p2_ds_q;
    assign bus.p2_din    = p2_din_q;
    assign bus.dbg_state = state_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_p2_arbiter.sv
// Directed bench for sdram_p2_arbiter: the bench plays both the clients and
// a hand-driven SDRAM controller that toggles p2_ack on completion.
module tb_sdram_p2_arbiter;
    localparam int N     = 3;
    localparam int TMO   = 255;
    localparam int DRAIN = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_p2_arbiter_if #(.NUM_CLIENTS(N)) bus();

    sdram_p2_arbiter #(
        .NUM_CLIENTS(N), .TIMEOUT_CYCLES(TMO), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic w, input logic [21:0] a,
                              input logic [1:0] s, input logic [15:0] d);
        bus.we[i]           = w;
        bus.addr[22*i +: 22] = a;
        bus.ds[2*i +: 2]     = s;
        bus.din[16*i +: 16]  = d;
    endtask

    // Wait (bounded) until the arbiter drives p2_cs.
    task automatic wait_grant(input string tag);
        int t;
        t = 0;
        while (!bus.p2_cs && t < 50) begin
            tick();
            t++;
        end
        check(tag, 32'(bus.p2_cs), 32'd1);
    endtask

    // Controller model: present read data and toggle the completion level.
    task automatic complete(input logic [15:0] d);
        bus.p2_dout = d;
        bus.p2_ack  = ~bus.p2_ack;
        tick();
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    logic [21:0] grant_addr;
    int          idx;
    int          cnt;
    logic        seen;

    initial begin
        bus.ready   = 1'b1;
        bus.req     = '0;
        bus.we      = '0;
        bus.addr    = '0;
        bus.ds      = '0;
        bus.din     = '0;
        bus.p2_dout = '0;
        bus.p2_ack  = 1'b0;
        reset       = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_cs",    32'(bus.p2_cs),     32'd0);
        check("rst_ack",   32'(bus.ack),       32'd0);
        check("rst_err",   32'(bus.err),       32'd0);
        check("rst_dout",  32'(bus.dout),      32'd0);
        check("rst_addr",  32'(bus.p2_addr),   32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        reset = 1'b0;

        // 1: single read by client 0
        set_client(0, 1'b0, 22'h012345, 2'b11, 16'h0);
        bus.req = 3'b001;
        tick();
        check("t1_cs_latency", 32'(bus.p2_cs),   32'd1);
        check("t1_addr",       32'(bus.p2_addr), 32'h012345);
        check("t1_we",         32'(bus.p2_we),   32'd0);
        tick();
        tick();
        check("t1_no_early_ack", 32'(bus.ack), 32'd0);
        complete(16'hBEEF);
        check("t1_ack",  32'(bus.ack),   32'b001);
        check("t1_err",  32'(bus.err),   32'd0);
        check("t1_dout", 32'(bus.dout),  32'hBEEF);
        check("t1_cs_low", 32'(bus.p2_cs), 32'd0);
        bus.req[0] = 1'b0;
        tick();
        check("t1_ack_pulse", 32'(bus.ack), 32'd0);
        tick();

        // 2: round-robin from reset: 0,1,2 then with 101: 0,2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_client(0, 1'b0, 22'h000100, 2'b11, 16'h0);
        set_client(1, 1'b0, 22'h000200, 2'b11, 16'h0);
        set_client(2, 1'b0, 22'h000300, 2'b11, 16'h0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(0); exp_q.push_back(2);
        bus.req = 3'b111;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) bus.req = 3'b101;
            wait_grant("t2_grant");
            grant_addr = bus.p2_addr;
            tick();
            complete(16'h1000 + 16'(i));
            idx = int'(exp_q.pop_front());
            check("t2_order", 32'(bus.ack), 32'(1 << idx));
            check("t2_addr",  32'(grant_addr), 32'h100 * 32'(idx + 1));
            bus.req = bus.req & ~bus.ack;
            tick();
        end
        check("t2_dout", 32'(bus.dout), 32'h1004);
        tick();

        // 3: write by client 1, p2_* stable, dout untouched
        set_client(1, 1'b1, 22'h02AAAA, 2'b01, 16'h55AA);
        bus.req = 3'b010;
        wait_grant("t3_grant");
        for (int c = 0; c < 4; c++) begin
            check("t3_we",   32'(bus.p2_we),   32'd1);
            check("t3_ds",   32'(bus.p2_ds),   32'b01);
            check("t3_din",  32'(bus.p2_din),  32'h55AA);
            check("t3_addr", 32'(bus.p2_addr), 32'h02AAAA);
            tick();
        end
        complete(16'hDEAD);
        check("t3_ack",  32'(bus.ack),  32'b010);
        check("t3_dout", 32'(bus.dout), 32'h1004);
        bus.req = '0;
        tick();
        tick();

        // 4: ready low blocks grants
        bus.ready = 1'b0;
        set_client(2, 1'b0, 22'h3FFFFF, 2'b10, 16'h0);
        bus.req = 3'b100;
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (bus.p2_cs) seen = 1'b1;
        end
        check("t4_blocked", 32'(seen), 32'd0);
        bus.ready = 1'b1;
        tick();
        check("t4_cs",   32'(bus.p2_cs),   32'd1);
        check("t4_addr", 32'(bus.p2_addr), 32'h3FFFFF);
        check("t4_ds",   32'(bus.p2_ds),   32'b10);
        complete(16'h7E57);
        check("t4_ack",  32'(bus.ack),  32'b100);
        check("t4_dout", 32'(bus.dout), 32'h7E57);
        bus.req = '0;
        tick();
        tick();

        // 5: reset mid-access, late toggle during reset must not complete later
        set_client(0, 1'b0, 22'h0ABCDE, 2'b11, 16'h0);
        bus.req = 3'b001;
        wait_grant("t5_grant");
        tick();
        reset = 1'b1;
        tick();
        check("t5_cs",    32'(bus.p2_cs),     32'd0);
        check("t5_ack",   32'(bus.ack),       32'd0);
        check("t5_state", 32'(bus.dbg_state), 32'd0);
        check("t5_dout",  32'(bus.dout),      32'd0);
        bus.p2_ack = ~bus.p2_ack;
        tick();
        reset = 1'b0;
        wait_grant("t5_regrant");
        tick();
        tick();
        tick();
        check("t5_no_false_ack", 32'(bus.ack),   32'd0);
        check("t5_still_busy",   32'(bus.p2_cs), 32'd1);
        complete(16'hC0DE);
        check("t5_ack2", 32'(bus.ack),  32'b001);
        check("t5_dout2", 32'(bus.dout), 32'hC0DE);
        bus.req = '0;
        tick();
        tick();

`ifdef SDRAM_ARB_TIMEOUT_EN
        // 6: controller never answers -> abort with err, drain absorbs late toggle
        set_client(1, 1'b0, 22'h000111, 2'b11, 16'h0);
        bus.req = 3'b010;
        wait_grant("t6_grant");
        cnt = 0;
        while (bus.ack == '0 && cnt < 400) begin
            tick();
            cnt++;
        end
        check("t6_timeout_cycles", 32'(cnt), 32'(TMO));
        check("t6_ack",  32'(bus.ack),   32'b010);
        check("t6_err",  32'(bus.err),   32'd1);
        check("t6_cs",   32'(bus.p2_cs), 32'd0);
        check("t6_dout", 32'(bus.dout),  32'hC0DE);
        bus.req = '0;
        tick();
        check("t6_ack_pulse", 32'(bus.ack), 32'd0);
        check("t6_err_pulse", 32'(bus.err), 32'd0);
        tick();
        tick();
        bus.p2_dout = 16'hBAD0;
        bus.p2_ack  = ~bus.p2_ack;
        seen = 1'b0;
        repeat (DRAIN + 2) begin
            tick();
            if (bus.ack != '0 || bus.p2_cs) seen = 1'b1;
        end
        check("t6_drain_quiet", 32'(seen), 32'd0);
        set_client(0, 1'b0, 22'h000222, 2'b11, 16'h0);
        bus.req = 3'b001;
        wait_grant("t6_next_grant");
        tick();
        check("t6_no_false_ack", 32'(bus.ack), 32'd0);
        complete(16'hF00D);
        check("t6_next_ack",  32'(bus.ack),  32'b001);
        check("t6_next_err",  32'(bus.err),  32'd0);
        check("t6_next_dout", 32'(bus.dout), 32'hF00D);
        bus.req = '0;
        tick();
`endif

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
